lif_neuron: RTL



---
 rtl/lif_neuron.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: synchronised spike-edge inputs, leaky membrane, fire and refractory FSM.
// Optional NEURON_LEAK_EN: when undefined, the leak term is forced to 0 and the neuron is a pure integrator.
module lif_neuron #(
    parameter int NUM_SYN    = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 100,
    parameter int WEIGHT     = 30,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRACTORY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SYN-1:0] spike_in,
    output logic               spike_out,
    output logic [WIDTH-1:0]   membrane,
    output logic               refractory,
    output logic [7:0]         drop_count
);

    // state     | meaning
    // INTEGRATE | leak and accumulate weighted input edges, fire on threshold
    // REFRACT   | membrane pinned at 0, input edges counted as dropped

    localparam int SW = WIDTH + 4;

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [NUM_SYN-1:0] sync1, sync2, sync3;
    logic [NUM_SYN-1:0] edges;
    logic [3:0]         n_edges;
    logic [SW-1:0]      leak;
    logic [SW-1:0]      sum_raw;
    logic [WIDTH-1:0]   sum_clamped;
    logic               fire;
    logic [8:0]         drop_sum;
    logic [7:0]         drop_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= spike_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edges = sync2 & ~sync3;

    always_comb begin
        n_edges = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            n_edges = n_edges + {3'b000, edges[i]};
        end
    end

`ifdef NEURON_LEAK_EN
    logic [WIDTH-1:0] shifted;
    assign shifted = membrane >> LEAK_SHIFT;

    // A nonzero potential always loses at least one unit so it eventually decays to 0.
    always_comb begin
        leak = '0;
        if (membrane != '0) begin
            leak = (shifted == '0) ? SW'(1) : {4'b0000, shifted};
        end
    end
`else
    assign leak = '0;
`endif

    // leak never exceeds the membrane value, so the subtraction cannot wrap.
    assign sum_raw     = {4'b0000, membrane} - leak + SW'(WEIGHT) * {{(SW-4){1'b0}}, n_edges};
    assign sum_clamped = (sum_raw[SW-1:WIDTH] != '0) ? {WIDTH{1'b1}} : sum_raw[WIDTH-1:0];
    assign fire        = (sum_raw >= SW'(THRESHOLD));

    assign drop_sum  = {1'b0, drop_count} + {5'b00000, n_edges};
    assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INTEGRATE;
            cnt        <= '0;
            spike_out  <= 1'b0;
            membrane   <= '0;
            refractory <= 1'b0;
            drop_count <= '0;
        end else begin
            case (state)
                INTEGRATE: begin
                    if (fire) begin
                        spike_out <= 1'b1;
                        membrane  <= '0;
                        if (REFRACTORY > 0) begin
                            state      <= REFRACT;
                            cnt        <= 8'(REFRACTORY);
                            refractory <= 1'b1;
                        end
                    end else begin
                        spike_out <= 1'b0;
                        membrane  <= sum_clamped;
                    end
                end
                REFRACT: begin
                    spike_out  <= 1'b0;
                    membrane   <= '0;
                    drop_count <= drop_next;
                    cnt        <= cnt - 8'd1;
                    // Terminal count: this edge takes the counter to zero.
                    if (cnt == 8'd1) begin
                        state      <= INTEGRATE;
                        refractory <= 1'b0;
                    end
                end
                default: begin
                    state <= INTEGRATE;
                end
            endcase
        end
    end

endmodule
